// File: rtl/svo_tmds_dec_if.sv
// svo_tmds_dec_if: lane bundle between an IDES10 deserialiser and svo_tmds_dec.
// master = decoder side (takes the symbol, drives decoded outputs and bitslip).
// slave  = environment side (drives the symbol, observes decoded outputs).
// Extra disparity signals exist only when SVO_TMDS_DEC_DISP_EN is defined.
interface svo_tmds_dec_if;
   logic [9:0] sym_in;
   logic       de;
   logic [1:0] ctrl;
   logic [7:0] dout;
   logic       bitslip;
   logic       aligned;
`ifdef SVO_TMDS_DEC_DISP_EN
   logic        disp_err;
   logic [15:0] err_cnt;

   modport master (input sym_in, output de, output ctrl, output dout,
                   output bitslip, output aligned, output disp_err, output err_cnt);
   modport slave  (output sym_in, input de, input ctrl, input dout,
                   input bitslip, input aligned, input disp_err, input err_cnt);
`else
   modport master (input sym_in, output de, output ctrl, output dout,
                   output bitslip, output aligned);
   modport slave  (output sym_in, input de, input ctrl, input dout,
                   input bitslip, input aligned);
`endif
endinterface

// File: rtl/svo_tmds_dec.sv
// svo_tmds_dec: decodes one deskewed TMDS lane (10-bit symbols, bit0 first on wire)
// into DE / {C1,C0} / pixel byte with one register stage, and runs a word-alignment
// FSM that pulses bitslip to the IDES10 until a run of identical control tokens
// is seen. Define SVO_TMDS_DEC_DISP_EN to add the running-disparity checker
// (disp_err pulse and saturating err_cnt).
module svo_tmds_dec #(
   parameter int CTRL_RUN   = 16,
   parameter int SEARCH_TMO = 2048,
   parameter int SLIP_WAIT  = 8,
   parameter int LOSS_TMO   = 4096
) (
   input  logic           clk_pixel,
   input  logic           reset,
   svo_tmds_dec_if.master lane
);
   localparam int RW = $clog2(CTRL_RUN) + 1;
   localparam int TW = $clog2(SEARCH_TMO) + 1;
   localparam int WW = $clog2(SLIP_WAIT) + 1;
   localparam int LW = $clog2(LOSS_TMO) + 1;

   localparam logic [RW-1:0] RUN_MAX   = RW'(CTRL_RUN);
   localparam logic [TW-1:0] TMO_LAST  = TW'(SEARCH_TMO - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_TMO - 1);

   localparam logic [9:0] TOK0 = 10'b1101010100;
   localparam logic [9:0] TOK1 = 10'b0010101011;
   localparam logic [9:0] TOK2 = 10'b0101010100;
   localparam logic [9:0] TOK3 = 10'b1010101011;

   localparam logic [1:0] ST_SEARCH = 2'd0, ST_SLIP = 2'd1, ST_WAIT = 2'd2, ST_LOCKED = 2'd3;

   // Undo the transition-minimising XOR/XNOR chain and optional inversion.
   function automatic logic [7:0] tmds_data(input logic [9:0] s);
      logic [7:0] d;
      logic [7:0] q;
      d    = s[9] ? ~s[7:0] : s[7:0];
      q[0] = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return q;
   endfunction

   logic          is_tok;
   logic [1:0]    tok_code;
   logic [9:0]    prev_sym;
   logic [RW-1:0] run_cnt;
   logic          run_hit;
   logic [1:0]    state, state_nxt;
   logic [TW-1:0] tmo_cnt;
   logic [WW-1:0] wait_cnt;
   logic [LW-1:0] loss_cnt;
   logic          de_p1, bitslip_p1, aligned_p1;
   logic [1:0]    ctrl_p1;
   logic [7:0]    dout_p1;

   assign run_hit = (run_cnt == RUN_MAX);

   // Classify the incoming symbol as one of the four control tokens or data.
   always_comb begin
      is_tok   = 1'b1;
      tok_code = 2'b00;
      case (lane.sym_in)
         TOK0:    tok_code = 2'b00;
         TOK1:    tok_code = 2'b01;
         TOK2:    tok_code = 2'b10;
         TOK3:    tok_code = 2'b11;
         default: is_tok = 1'b0;
      endcase
   end

   // ---- stage p1: decoded outputs, registered once from sym_in ----
   // Decode register; ctrl keeps its last token value through data periods.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         de_p1   <= 1'b0;
         ctrl_p1 <= 2'b00;
         dout_p1 <= 8'h00;
      end else if (is_tok) begin
         de_p1   <= 1'b0;
         ctrl_p1 <= tok_code;
         dout_p1 <= 8'h00;
      end else begin
         de_p1   <= 1'b1;
         dout_p1 <= tmds_data(lane.sym_in);
      end
   end

   // Length of the current run of identical control tokens, saturating; held at 0 while settling.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         prev_sym <= '0;
         run_cnt  <= '0;
      end else begin
         prev_sym <= lane.sym_in;
         if (state == ST_WAIT)
            run_cnt <= '0;
         else if (is_tok && (lane.sym_in == prev_sym)) begin
            if (run_cnt != RUN_MAX)
               run_cnt <= run_cnt + 1'b1;
         end else if (is_tok)
            run_cnt <= RW'(1);
         else
            run_cnt <= '0;
      end
   end

   // Alignment FSM next state; a run hit in SEARCH wins over the slip timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_SEARCH: if (run_hit) state_nxt = ST_LOCKED;
                    else if (tmo_cnt == TMO_LAST) state_nxt = ST_SLIP;
         ST_SLIP:   state_nxt = ST_WAIT;
         ST_WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = ST_SEARCH;
         ST_LOCKED: if (!run_hit && (loss_cnt == LOSS_LAST)) state_nxt = ST_SEARCH;
         default:   state_nxt = ST_SEARCH;
      endcase
   end

   // FSM state, per-state counters (cleared whenever the state changes) and registered status.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state      <= ST_SEARCH;
         tmo_cnt    <= '0;
         wait_cnt   <= '0;
         loss_cnt   <= '0;
         bitslip_p1 <= 1'b0;
         aligned_p1 <= 1'b0;
      end else begin
         state      <= state_nxt;
         bitslip_p1 <= (state_nxt == ST_SLIP);
         aligned_p1 <= (state_nxt == ST_LOCKED);
         tmo_cnt    <= (state == ST_SEARCH && state_nxt == ST_SEARCH) ? tmo_cnt + 1'b1 : '0;
         wait_cnt   <= (state == ST_WAIT && state_nxt == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         if (state == ST_LOCKED && state_nxt == ST_LOCKED)
            loss_cnt <= run_hit ? '0 : loss_cnt + 1'b1;
         else
            loss_cnt <= '0;
      end
   end

   assign lane.de      = de_p1;
   assign lane.ctrl    = ctrl_p1;
   assign lane.dout    = dout_p1;
   assign lane.bitslip = bitslip_p1;
   assign lane.aligned = aligned_p1;

`ifdef SVO_TMDS_DEC_DISP_EN
   // Ones minus zeros over all ten bits of a symbol.
   function automatic logic signed [7:0] sym_balance(input logic [9:0] s);
      logic signed [7:0] acc;
      acc = -8'sd10;
      for (int i = 0; i < 10; i++)
         if (s[i]) acc = acc + 8'sd2;
      return acc;
   endfunction

   logic signed [7:0] disp_p1;
   logic signed [7:0] disp_sum;
   logic              disp_bad;
   logic              disp_err_p1;
   logic [15:0]       err_cnt_p1;

   // Candidate running disparity and the out-of-range test for data symbols.
   always_comb begin
      disp_sum = disp_p1 + sym_balance(lane.sym_in);
      disp_bad = !is_tok && ((disp_sum > 8'sd16) || (disp_sum < -8'sd16));
   end

   // ---- stage p1: disparity error pulse aligned with dout ----
   // Running disparity (restarted by tokens and after each error) and the aligned-only error count.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         disp_p1     <= '0;
         disp_err_p1 <= 1'b0;
         err_cnt_p1  <= '0;
      end else begin
         disp_p1     <= (is_tok || disp_bad) ? 8'sd0 : disp_sum;
         disp_err_p1 <= disp_bad;
         if (state == ST_LOCKED && state_nxt == ST_SEARCH)
            err_cnt_p1 <= '0;
         else if (disp_bad && aligned_p1 && (err_cnt_p1 != 16'hFFFF))
            err_cnt_p1 <= err_cnt_p1 + 16'd1;
      end
   end

   assign lane.disp_err = disp_err_p1;
   assign lane.err_cnt  = err_cnt_p1;
`endif
endmodule
